// File: rtl/picomips_pkg.sv
// picomips_pkg: shared types for the picoMips peripheral blocks.
//   hs_state_t  handshake FSM states. The encoding puts the Handshake level
//               in bit 1, so the output is a single state flop.
//   hs_level()  Handshake level for a given state.
package picomips_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        DB_PRESS   = 2'b01,
        HELD       = 2'b10,
        DB_RELEASE = 2'b11
    } hs_state_t;

    function automatic logic hs_level(input hs_state_t s);
        return s[1];
    endfunction

endpackage

// File: rtl/io_handshake_sync.sv
// synchroniser: multi-flop synchroniser chain for a bus of asynchronous inputs.
//   clk    in   1      sampling clock
//   reset  in   1      asynchronous, active-high; clears every stage
//   d      in   WIDTH  asynchronous input
//   q      out  WIDTH  synchronised output, STAGES cycles behind d
module synchroniser #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] sync_q;
    logic [STAGES-1:0][WIDTH-1:0] sync_d;

    // Stage 0 takes the raw input; each later stage takes its predecessor.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/io_handshake.sv
// io_handshake: peripheral end of the picoMips wait-for-handshake protocol.
// Synchronises and debounces the push-button. It exposes a registered
// Handshake level and a switch snapshot taken when a press is accepted.
//   clk        in   1      system clock
//   reset      in   1      asynchronous, active-high reset
//   Button     in   1      raw push-button (active-high, bouncy)
//   Switches   in   WIDTH  raw switch bank
//   Handshake  out  1      1 while a debounced press is held; data valid
//   SwData     out  WIDTH  switch snapshot latched at press acceptance
module io_handshake
    import picomips_pkg::*;
#(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Button,
    input  logic [WIDTH-1:0] Switches,
    output logic             Handshake,
    output logic [WIDTH-1:0] SwData
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             btn_s;
    logic [WIDTH-1:0] sw_s;

    hs_state_t        state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] sw_data_q, sw_data_d;

    synchroniser #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_btn (
        .clk   (clk),
        .reset (reset),
        .d     (Button),
        .q     (btn_s)
    );

    synchroniser #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync_sw (
        .clk   (clk),
        .reset (reset),
        .d     (Switches),
        .q     (sw_s)
    );

    // The counter only advances below CNT_MAX, so it saturates rather than wraps.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        sw_data_d = sw_data_q;
        case (state_q)
            IDLE: begin
                if (btn_s) begin
                    state_d = DB_PRESS;
                    count_d = '0;
                end
            end
            DB_PRESS: begin
                if (!btn_s) begin
                    state_d = IDLE;
                end else if (count_q == CNT_MAX) begin
                    state_d   = HELD;
                    sw_data_d = sw_s;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_d = DB_RELEASE;
                    count_d = '0;
                end
            end
            DB_RELEASE: begin
                if (btn_s) begin
                    state_d = HELD;
                end else if (count_q == CNT_MAX) begin
                    state_d = IDLE;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            sw_data_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            sw_data_q <= sw_data_d;
        end
    end

    // Decoded from a single state flop: glitch-free, no path from inputs.
    assign Handshake = hs_level(state_q);
    assign SwData    = sw_data_q;

endmodule

// File: tb/tb_io_handshake.sv
module tb_io_handshake;

    logic       clk = 1'b0;
    logic       reset;
    logic       Button;
    logic [7:0] Switches;
    logic       Handshake;
    logic [7:0] SwData;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] sb_q[$];

    io_handshake #(
        .WIDTH           (8),
        .DEBOUNCE_CYCLES (4),
        .SYNC_STAGES     (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .Button    (Button),
        .Switches  (Switches),
        .Handshake (Handshake),
        .SwData    (SwData)
    );

    always #5 clk = ~clk;

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Count negedges until Handshake reaches v; gives up after maxc.
    task automatic wait_hs(input logic v, input int maxc, output int n);
        n = 0;
        while (Handshake !== v && n < maxc) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Scoreboard: compare SwData against the oldest expected snapshot.
    task automatic sb_pop(input string tag);
        logic [7:0] e;
        if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s: got %0h expected <empty scoreboard>", tag, SwData);
        end else begin
            e = sb_q.pop_front();
            chk_val(tag, {24'b0, SwData}, {24'b0, e});
        end
    endtask

    initial begin
        int n;
        int pc, cyc, hold0, hold1;
        logic [7:0] cpu_reg;

        reset = 1'b1; Button = 1'b0; Switches = 8'h00;
        #1;
        chk_bit("rst_hs", Handshake, 1'b0);
        chk_val("rst_sw", {24'b0, SwData}, 32'h0);
        tick(2);
        reset = 1'b0;
        tick(2);
        chk_bit("idle_hs", Handshake, 1'b0);

        // Clean press
        Switches = 8'hA5; sb_q.push_back(8'hA5);
        Button = 1'b1;
        wait_hs(1'b1, 20, n);
        chk_val("press_lat", n, 7);
        sb_pop("press_data");

        // Data hold while HELD
        Switches = 8'h3C;
        tick(5);
        chk_bit("hold_hs", Handshake, 1'b1);
        chk_val("hold_data", {24'b0, SwData}, 32'hA5);

        // Clean release; SwData persists in IDLE
        Button = 1'b0;
        wait_hs(1'b0, 20, n);
        chk_val("release_lat", n, 7);
        tick(3);
        chk_val("idle_data", {24'b0, SwData}, 32'hA5);

        // Bounce reject: high 3, low 1, high again
        Button = 1'b1; tick(3);
        chk_bit("bounce_hs_a", Handshake, 1'b0);
        Button = 1'b0; tick(1);
        chk_bit("bounce_hs_b", Handshake, 1'b0);
        sb_q.push_back(8'h3C);
        Button = 1'b1;
        wait_hs(1'b1, 20, n);
        chk_val("bounce_lat", n, 7);
        sb_pop("bounce_data");

        // Release bounce: low 2 then high
        Button = 1'b0; tick(2);
        Button = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk_bit("relbounce_hs", Handshake, 1'b1);
            tick(1);
        end
        chk_val("relbounce_data", {24'b0, SwData}, 32'h3C);
        Button = 1'b0;
        wait_hs(1'b0, 20, n);
        chk_val("relbounce_lat", n, 7);

        // Async reset mid-DB_PRESS
        Switches = 8'h77;
        Button = 1'b1;
        tick(4);
        #2 reset = 1'b1;
        #1;
        chk_bit("rstpress_hs", Handshake, 1'b0);
        chk_val("rstpress_sw", {24'b0, SwData}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        sb_q.push_back(8'h77);
        wait_hs(1'b1, 20, n);
        chk_val("rstpress_lat", n, 7);
        sb_pop("rstpress_data");

        // Async reset mid-HELD
        tick(2);
        #2 reset = 1'b1;
        #1;
        chk_bit("rstheld_hs", Handshake, 1'b0);
        chk_val("rstheld_sw", {24'b0, SwData}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        sb_q.push_back(8'h77);
        wait_hs(1'b1, 20, n);
        chk_val("rstheld_lat", n, 7);
        sb_pop("rstheld_data");
        Button = 1'b0;
        wait_hs(1'b0, 20, n);
        chk_val("rstheld_rel", n, 7);

        // CPU loop: wait(0) / read / wait(1)
        Switches = 8'hA5;
        cpu_reg = 8'h00;
        pc = 0; cyc = 0; hold0 = 0; hold1 = 0;
        Button = 1'b1;
        while (pc < 3 && cyc < 100) begin
            case (pc)
                0: if (Handshake == 1'b0) hold0++; else pc = 1;
                1: begin
                    chk_bit("cpu_valid", Handshake, 1'b1);
                    cpu_reg = SwData;
                    Button  = 1'b0;
                    pc = 2;
                end
                2: if (Handshake == 1'b1) hold1++; else pc = 3;
                default: pc = 3;
            endcase
            @(negedge clk);
            cyc++;
        end
        chk_val("cpu_done", pc, 3);
        chk_val("cpu_hold0", hold0, 7);
        chk_val("cpu_hold1", hold1, 6);
        chk_val("cpu_reg", {24'b0, cpu_reg}, 32'hA5);

        chk_val("sb_empty", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
